// File: rtl/multicycle_control_fsm_pkg.sv
// Shared definitions for the multi-cycle RV32I control FSM: state encodings,
// datapath mux codes, opcodes and the bundled control-output struct.
package multicycle_control_fsm_pkg;

    typedef enum logic [3:0] {
        S_IF       = 4'd0,
        S_ID       = 4'd1,
        S_EX_R     = 4'd2,
        S_EX_I     = 4'd3,
        S_WB_ALU   = 4'd4,
        S_EX_ADDR  = 4'd5,
        S_MEM_LD   = 4'd6,
        S_WB_LD    = 4'd7,
        S_MEM_ST   = 4'd8,
        S_EX_BR    = 4'd9,
        S_BR_TAKEN = 4'd10,
        S_EX_JAL   = 4'd11,
        S_EX_JALR  = 4'd12,
        S_PC_INC   = 4'd13,
        S_HALT     = 4'd14
    } state_t;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

    localparam logic PCSRC_ALU    = 1'b0;
    localparam logic PCSRC_ALUOUT = 1'b1;

    localparam logic [6:0] OP_ARITH     = 7'b0110011;
    localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM    = 7'b1110011;

    typedef struct packed {
        logic       pc_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       pc_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       pc_source;
        logic       is_ecall;
        logic       is_halted;
        logic       instr_done;
    } ctrl_t;

endpackage

// File: rtl/mc_output_decode.sv
// Combinational control decode: current state plus the mem_ready/bcond Mealy
// terms produce every datapath mux select and write enable.
module mc_output_decode
    import multicycle_control_fsm_pkg::*;
(
    input  logic       reset,
    input  state_t     st,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    input  logic       bcond,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        if (!reset) begin
            case (st)
                S_IF: begin
                    ctrl.mem_read = 1'b1;
                    ctrl.ir_write = mem_ready;
                end
                S_ID: begin
                    // ALUOut <= PC+4 so branches and jumps can reuse it later
                    ctrl.alu_src_b = SRCB_FOUR;
                    ctrl.is_ecall  = (opcode == OP_SYSTEM);
                end
                S_EX_R: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_REG;
                    ctrl.alu_op    = ALUOP_FUNCT;
                end
                S_EX_I: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    ctrl.alu_op    = ALUOP_FUNCT;
                end
                S_WB_ALU, S_PC_INC: begin
                    ctrl.reg_write  = (st == S_WB_ALU);
                    ctrl.alu_src_b  = SRCB_FOUR;
                    ctrl.pc_source  = PCSRC_ALU;
                    ctrl.pc_write   = 1'b1;
                    ctrl.instr_done = 1'b1;
                end
                S_EX_ADDR: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    ctrl.alu_op    = ALUOP_ADD;
                end
                S_MEM_LD: begin
                    ctrl.iord     = 1'b1;
                    ctrl.mem_read = 1'b1;
                end
                S_WB_LD: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                    ctrl.alu_src_b  = SRCB_FOUR;
                    ctrl.pc_write   = 1'b1;
                    ctrl.instr_done = 1'b1;
                end
                S_MEM_ST: begin
                    ctrl.iord      = 1'b1;
                    ctrl.mem_write = 1'b1;
                    if (mem_ready) begin
                        ctrl.alu_src_b  = SRCB_FOUR;
                        ctrl.pc_write   = 1'b1;
                        ctrl.instr_done = 1'b1;
                    end
                end
                S_EX_BR: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_REG;
                    ctrl.alu_op    = ALUOP_BRANCH;
                    // Not taken: ALUOut still holds PC+4 from ID
                    if (!bcond) begin
                        ctrl.pc_source  = PCSRC_ALUOUT;
                        ctrl.pc_write   = 1'b1;
                        ctrl.instr_done = 1'b1;
                    end
                end
                S_BR_TAKEN: begin
                    ctrl.alu_src_b  = SRCB_IMM;
                    ctrl.pc_source  = PCSRC_ALU;
                    ctrl.pc_write   = 1'b1;
                    ctrl.instr_done = 1'b1;
                end
                S_EX_JAL, S_EX_JALR: begin
                    // Link value is ALUOut (PC+4); A was latched in ID so rd==rs1 is safe
                    ctrl.reg_write  = 1'b1;
                    ctrl.pc_to_reg  = 1'b1;
                    ctrl.alu_src_a  = (st == S_EX_JALR);
                    ctrl.alu_src_b  = SRCB_IMM;
                    ctrl.alu_op     = ALUOP_ADD;
                    ctrl.pc_source  = PCSRC_ALU;
                    ctrl.pc_write   = 1'b1;
                    ctrl.instr_done = 1'b1;
                end
                S_HALT: ctrl.is_halted = 1'b1;
                default: ctrl = '0;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control FSM: state register and next-state logic; the
// control outputs come from mc_output_decode.
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
#(
    parameter logic [31:0] HALT_CODE = 32'd10,
    parameter int          STATE_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         opcode,
    input  logic [31:0]        rf17,
    input  logic               bcond,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               pc_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic               pc_source,
    output logic               is_ecall,
    output logic               is_halted,
    output logic               instr_done,
    output logic [STATE_W-1:0] state
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IF;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IF:     if (mem_ready) state_d = S_ID;
            S_ID: begin
                case (opcode)
                    OP_ARITH:          state_d = S_EX_R;
                    OP_ARITH_IMM:      state_d = S_EX_I;
                    OP_LOAD, OP_STORE: state_d = S_EX_ADDR;
                    OP_BRANCH:         state_d = S_EX_BR;
                    OP_JAL:            state_d = S_EX_JAL;
                    OP_JALR:           state_d = S_EX_JALR;
                    OP_SYSTEM:         state_d = (rf17 == HALT_CODE) ? S_HALT : S_PC_INC;
                    default:           state_d = S_PC_INC;
                endcase
            end
            S_EX_R, S_EX_I: state_d = S_WB_ALU;
            S_EX_ADDR:      state_d = (opcode == OP_LOAD) ? S_MEM_LD : S_MEM_ST;
            S_MEM_LD:       if (mem_ready) state_d = S_WB_LD;
            S_MEM_ST:       if (mem_ready) state_d = S_IF;
            S_EX_BR:        state_d = bcond ? S_BR_TAKEN : S_IF;
            S_HALT:         state_d = S_HALT;
            S_WB_ALU, S_WB_LD, S_BR_TAKEN,
            S_EX_JAL, S_EX_JALR, S_PC_INC: state_d = S_IF;
            default:        state_d = S_IF;
        endcase
    end

    mc_output_decode u_decode (
        .reset     (reset),
        .st        (state_q),
        .opcode    (opcode),
        .mem_ready (mem_ready),
        .bcond     (bcond),
        .ctrl      (ctrl)
    );

    assign pc_write   = ctrl.pc_write;
    assign iord       = ctrl.iord;
    assign mem_read   = ctrl.mem_read;
    assign mem_write  = ctrl.mem_write;
    assign ir_write   = ctrl.ir_write;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign pc_to_reg  = ctrl.pc_to_reg;
    assign reg_write  = ctrl.reg_write;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alu_op     = ctrl.alu_op;
    assign pc_source  = ctrl.pc_source;
    assign is_ecall   = ctrl.is_ecall;
    assign is_halted  = ctrl.is_halted;
    assign instr_done = ctrl.instr_done;

    // IF encodes as zero, so the forced-zero debug state during reset reads as IF
    assign state = reset ? '0 : STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Cycle-by-cycle bench for multicycle_control_fsm: every cycle's expected state
// and control vector is queued from a table of the state outputs and compared.
module tb_multicycle_control_fsm;
    import multicycle_control_fsm_pkg::*;

    localparam int W = 21;

    localparam logic [6:0] TB_R    = 7'b0110011;
    localparam logic [6:0] TB_IMM  = 7'b0010011;
    localparam logic [6:0] TB_LD   = 7'b0000011;
    localparam logic [6:0] TB_ST   = 7'b0100011;
    localparam logic [6:0] TB_BR   = 7'b1100011;
    localparam logic [6:0] TB_JAL  = 7'b1101111;
    localparam logic [6:0] TB_JALR = 7'b1100111;
    localparam logic [6:0] TB_SYS  = 7'b1110011;

    localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BNT = 4, K_BT = 5;
    localparam int K_JAL = 6, K_JALR = 7, K_ECALL = 8, K_NOP = 9;

    logic        clk;
    logic        reset;
    logic [6:0]  opcode;
    logic [31:0] rf17;
    logic        bcond;
    logic        mem_ready;
    logic        pc_write, iord, mem_read, mem_write, ir_write;
    logic        mem_to_reg, pc_to_reg, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, alu_op;
    logic        pc_source, is_ecall, is_halted, instr_done;
    logic [3:0]  state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pcw_cnt, rw_cnt, done_cnt;
    logic [W-1:0] exp_q[$];

    multicycle_control_fsm #(.HALT_CODE(32'd10), .STATE_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .rf17       (rf17),
        .bcond      (bcond),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .mem_to_reg (mem_to_reg),
        .pc_to_reg  (pc_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_source  (pc_source),
        .is_ecall   (is_ecall),
        .is_halted  (is_halted),
        .instr_done (instr_done),
        .state      (state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected control outputs of each state, taken from the state table
    function automatic logic [16:0] golden(state_t s, logic mr, logic bc, logic [6:0] op);
        logic pcw, io, mrd, mwr, irw, m2r, p2r, rw, sa, pcs, ec, hl, dn;
        logic [1:0] sb, ao;
        {pcw, io, mrd, mwr, irw, m2r, p2r, rw, sa, pcs, ec, hl, dn} = '0;
        sb = 2'b00;
        ao = 2'b00;
        case (s)
            S_IF:       begin mrd = 1; irw = mr; end
            S_ID:       begin sb = 2'b01; ec = (op == TB_SYS); end
            S_EX_R:     begin sa = 1; sb = 2'b00; ao = 2'b10; end
            S_EX_I:     begin sa = 1; sb = 2'b10; ao = 2'b10; end
            S_WB_ALU:   begin rw = 1; sb = 2'b01; pcw = 1; dn = 1; end
            S_EX_ADDR:  begin sa = 1; sb = 2'b10; end
            S_MEM_LD:   begin io = 1; mrd = 1; end
            S_WB_LD:    begin rw = 1; m2r = 1; sb = 2'b01; pcw = 1; dn = 1; end
            S_MEM_ST:   begin io = 1; mwr = 1; if (mr) begin sb = 2'b01; pcw = 1; dn = 1; end end
            S_EX_BR:    begin sa = 1; ao = 2'b01; if (!bc) begin pcs = 1; pcw = 1; dn = 1; end end
            S_BR_TAKEN: begin sb = 2'b10; pcw = 1; dn = 1; end
            S_EX_JAL:   begin rw = 1; p2r = 1; sb = 2'b10; pcw = 1; dn = 1; end
            S_EX_JALR:  begin rw = 1; p2r = 1; sa = 1; sb = 2'b10; pcw = 1; dn = 1; end
            S_PC_INC:   begin sb = 2'b01; pcw = 1; dn = 1; end
            S_HALT:     hl = 1;
            default:    ;
        endcase
        return {pcw, io, mrd, mwr, irw, m2r, p2r, rw, sa, sb, ao, pcs, ec, hl, dn};
    endfunction

    // ---------------- driver ----------------
    // Called just after a rising edge: drive, queue the expectation, check at the falling edge.
    task automatic step(input state_t es, input logic mr, input logic bc, input logic rst,
                        input string tag);
        logic [W-1:0] e, a;
        reset     = rst;
        mem_ready = mr;
        bcond     = bc;
        exp_q.push_back(rst ? {W{1'b0}} : {es, golden(es, mr, bc, opcode)});
        @(negedge clk);
        e = exp_q.pop_front();
        a = {state, pc_write, iord, mem_read, mem_write, ir_write, mem_to_reg, pc_to_reg,
             reg_write, alu_src_a, alu_src_b, alu_op, pc_source, is_ecall, is_halted, instr_done};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, a, e);
        end
        checks++;
        if (mem_read === 1'b1 && mem_write === 1'b1) begin
            errors++;
            $display("FAIL %s cycle %0d rd_wr_overlap: got 1 expected 0", tag, cyc);
        end
        pcw_cnt  += int'(pc_write);
        rw_cnt   += int'(reg_write);
        done_cnt += int'(instr_done);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic begin_instr(input logic [6:0] op, input logic [31:0] r17);
        opcode   = op;
        rf17     = r17;
        pcw_cnt  = 0;
        rw_cnt   = 0;
        done_cnt = 0;
    endtask

    task automatic end_instr(input string tag, input int e_pcw, input int e_rw, input int e_done);
        checks++;
        if (pcw_cnt != e_pcw) begin
            errors++;
            $display("FAIL %s pc_write_count: got %0d expected %0d", tag, pcw_cnt, e_pcw);
        end
        checks++;
        if (rw_cnt != e_rw) begin
            errors++;
            $display("FAIL %s reg_write_count: got %0d expected %0d", tag, rw_cnt, e_rw);
        end
        checks++;
        if (done_cnt != e_done) begin
            errors++;
            $display("FAIL %s instr_done_count: got %0d expected %0d", tag, done_cnt, e_done);
        end
    endtask

    function automatic logic [6:0] kind_op(int k);
        case (k)
            K_R:           return TB_R;
            K_I:           return TB_IMM;
            K_LD:          return TB_LD;
            K_ST:          return TB_ST;
            K_BNT, K_BT:   return TB_BR;
            K_JAL:         return TB_JAL;
            K_JALR:        return TB_JALR;
            K_ECALL:       return TB_SYS;
            default:       return 7'b0000000;
        endcase
    endfunction

    // One complete instruction; don't-care inputs get random values
    task automatic run_instr(input int k, input int if_stall, input int mem_stall, input string tag);
        logic rnd;
        int   e_rw;
        begin_instr(kind_op(k), (k == K_ECALL) ? 32'd9 : 32'($urandom_range(11, 40)));
        for (int i = 0; i < if_stall; i++) step(S_IF, 1'b0, 1'($urandom_range(0, 1)), 1'b0, tag);
        step(S_IF, 1'b1, 1'($urandom_range(0, 1)), 1'b0, tag);
        rnd = 1'($urandom_range(0, 1));
        step(S_ID, rnd, 1'($urandom_range(0, 1)), 1'b0, tag);
        case (k)
            K_R, K_I: begin
                step((k == K_R) ? S_EX_R : S_EX_I, rnd, rnd, 1'b0, tag);
                step(S_WB_ALU, rnd, ~rnd, 1'b0, tag);
            end
            K_LD: begin
                step(S_EX_ADDR, rnd, rnd, 1'b0, tag);
                for (int i = 0; i < mem_stall; i++) step(S_MEM_LD, 1'b0, rnd, 1'b0, tag);
                step(S_MEM_LD, 1'b1, rnd, 1'b0, tag);
                step(S_WB_LD, rnd, rnd, 1'b0, tag);
            end
            K_ST: begin
                step(S_EX_ADDR, rnd, rnd, 1'b0, tag);
                for (int i = 0; i < mem_stall; i++) step(S_MEM_ST, 1'b0, rnd, 1'b0, tag);
                step(S_MEM_ST, 1'b1, rnd, 1'b0, tag);
            end
            K_BNT: step(S_EX_BR, rnd, 1'b0, 1'b0, tag);
            K_BT: begin
                step(S_EX_BR, rnd, 1'b1, 1'b0, tag);
                step(S_BR_TAKEN, rnd, rnd, 1'b0, tag);
            end
            K_JAL:  step(S_EX_JAL, rnd, rnd, 1'b0, tag);
            K_JALR: step(S_EX_JALR, rnd, rnd, 1'b0, tag);
            default: step(S_PC_INC, rnd, rnd, 1'b0, tag);
        endcase
        e_rw = (k == K_R || k == K_I || k == K_LD || k == K_JAL || k == K_JALR) ? 1 : 0;
        end_instr(tag, 1, e_rw, 1);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        begin_instr(TB_ST, 32'd0);
        step(S_IF, 1'b1, 1'b1, 1'b1, "reset");
        step(S_IF, 1'b1, 1'b1, 1'b1, "reset");
        end_instr("reset", 0, 0, 0);
    endtask

    task automatic test_basic();
        run_instr(K_R, 0, 0, "add");
        run_instr(K_I, 0, 0, "addi");
        run_instr(K_LD, 0, 3, "load_wait");
        run_instr(K_ST, 0, 0, "store");
        run_instr(K_BNT, 0, 0, "beq_not_taken");
        run_instr(K_BT, 0, 0, "beq_taken");
        run_instr(K_JAL, 0, 0, "jal");
        run_instr(K_JALR, 0, 0, "jalr");
        run_instr(K_ECALL, 0, 0, "ecall_9");
        run_instr(K_NOP, 0, 0, "nop_opcode0");
        run_instr(K_R, 2, 0, "fetch_wait");
    endtask

    task automatic test_reset_mid_store();
        begin_instr(TB_ST, 32'd0);
        step(S_IF, 1'b1, 1'b0, 1'b0, "rst_store");
        step(S_ID, 1'b1, 1'b0, 1'b0, "rst_store");
        step(S_EX_ADDR, 1'b1, 1'b0, 1'b0, "rst_store");
        step(S_MEM_ST, 1'b0, 1'b0, 1'b0, "rst_store");
        step(S_IF, 1'b0, 1'b0, 1'b1, "rst_store");
        step(S_IF, 1'b0, 1'b0, 1'b1, "rst_store");
        step(S_IF, 1'b0, 1'b0, 1'b0, "rst_store");
        end_instr("rst_store", 0, 0, 0);
        run_instr(K_ST, 0, 1, "after_reset_store");
    endtask

    task automatic test_halt();
        begin_instr(TB_SYS, 32'd10);
        step(S_IF, 1'b1, 1'b0, 1'b0, "halt");
        step(S_ID, 1'b1, 1'b0, 1'b0, "halt");
        for (int i = 0; i < 22; i++)
            step(S_HALT, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, "halt");
        end_instr("halt", 0, 0, 0);
        step(S_IF, 1'b1, 1'b0, 1'b1, "halt_reset");
        run_instr(K_R, 0, 0, "after_halt");
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 40; n++)
            run_instr($urandom_range(K_R, K_NOP), $urandom_range(0, 2), $urandom_range(0, 3),
                      "random");
    endtask

    initial begin
        reset     = 1'b1;
        opcode    = 7'd0;
        rf17      = 32'd0;
        bcond     = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_reset_mid_store();
        test_halt();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL exp_q_drain: got %0d expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
